// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
// Optional write bypass is selected with REGFILE_WR_BYPASS_EN.
package regfile_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 3;

  typedef enum logic {
    RF_IDLE,
    RF_SWEEP
  } rf_state_t;

endpackage

// File: rtl/regfile_read_port.sv
// One asynchronous read port: DEPTH:1 mux plus optional write forwarding.
// Forwarding is compiled in with REGFILE_WR_BYPASS_EN.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic [(2**ADDR_W)*DATA_W-1:0] regs_flat,
  input  logic [ADDR_W-1:0]             rd_addr,
  input  logic                          wr_acc,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  output logic [DATA_W-1:0]             rd_data
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mux_data;

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        mux_data = regs_flat[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef REGFILE_WR_BYPASS_EN
  assign rd_data = (wr_acc && (wr_addr == rd_addr)) ? wr_data : mux_data;
`else
  logic unused_byp;
  assign unused_byp = ^{wr_acc, wr_addr, wr_data};
  assign rd_data    = mux_data;
`endif

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with sequenced bulk clear.
// Define REGFILE_WR_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic [NUM_RD*ADDR_W-1:0]      rd_addr,
  output logic [NUM_RD*DATA_W-1:0]      rd_data,
  input  logic                          clr_req,
  output logic                          clr_busy,
  output logic                          clr_done,
  output logic                          wr_rej,
  output logic [(2**ADDR_W)*DATA_W-1:0] dbg_regs
);

  localparam int DEPTH = 2**ADDR_W;

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic              wr_acc;
  logic              last;

  assign clr_busy = (state_q == RF_SWEEP);
  assign last     = (idx_q == ADDR_W'(DEPTH-1));
  assign clr_done = clr_busy && last;
  assign wr_rej   = wr_en && clr_busy;
  assign wr_acc   = wr_en && !clr_busy;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    regs_d  = regs_q;
    unique case (state_q)
      RF_IDLE: begin
        if (wr_en) regs_d[wr_addr] = wr_data;
        if (clr_req) begin
          state_d = RF_SWEEP;
          idx_d   = '0;
        end
      end
      RF_SWEEP: begin
        regs_d[idx_q] = '0;
        idx_d         = idx_q + 1'b1;
        if (last) state_d = RF_IDLE;
      end
      default: state_d = RF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RF_IDLE;
      idx_q   <= '0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      regs_q  <= regs_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_dbg
    assign dbg_regs[i*DATA_W +: DATA_W] = regs_q[i];
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_read_port #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_rd (
      .regs_flat(dbg_regs),
      .rd_addr  (rd_addr[k*ADDR_W +: ADDR_W]),
      .wr_acc   (wr_acc),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_data  (rd_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file; successor to the 8x16 two-read-port register file in the datapath.
- Generalised in width, depth and read-port count.
- Adds synchronous reset and a sequenced bulk-clear engine with a busy/done handshake.
- Exposes a flattened debug view of all registers.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers.
- NUM_RD, 2, number of independent asynchronous read ports (1..8).

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- wr_en  in  1  write request for this cycle.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W].
- clr_req  in  1  request a clear of all registers.
- clr_busy  out  1  clear sweep in progress.
- clr_done  out  1  one-cycle pulse on the last sweep cycle.
- wr_rej  out  1  one-cycle pulse: a write was rejected because a sweep was active.
- dbg_regs  out  DEPTH*DATA_W  all registers flattened; reg i at bits [i*DATA_W +: DATA_W].

Behaviour:
- Reset (rst_n=0 at posedge): all registers 0; state IDLE; sweep index 0; clr_busy=0, clr_done=0, wr_rej=0.
  - Reset overrides every other input in that cycle.
  - Reset mid-sweep aborts the sweep; no clr_done pulse is issued.
- Reads: combinational, zero latency; rd_data[k] = reg[rd_addr[k]]. All ports are independent, and any ports may share an address.
- Write, state IDLE: if wr_en=1, reg[wr_addr] <= wr_data at the posedge. The new value is visible on reads in the next cycle. All other registers hold.
- State machine with states IDLE and SWEEP:
  - IDLE -> SWEEP when clr_req=1 at a posedge. The sweep index loads 0 and clr_busy rises in the next cycle.
  - In SWEEP, each posedge does reg[idx] <= 0 and idx <= idx+1.
  - The sweep takes exactly DEPTH cycles; clr_busy=1 throughout.
  - clr_done=1 during the cycle idx==DEPTH-1. The FSM returns to IDLE at that edge, and clr_busy=0 in the following cycle.
  - The index is ADDR_W bits wide and wraps to 0 on exit.
- Simultaneous events:
  - clr_req and wr_en in the same IDLE cycle: the write is performed, then the sweep starts next cycle. The write is therefore subsequently cleared.
  - wr_en=1 while in SWEEP: the write is dropped, no register changes from it, and wr_rej=1 in that same cycle (combinational on wr_en & busy).
  - clr_req while in SWEEP: ignored, with no restart or extension.
- Reads during SWEEP return current contents. Already-swept registers read 0; unswept registers still hold old values.

Optional Feature:
- Macro: REGFILE_WR_BYPASS_EN.
- Defined: same-cycle write-to-read forwarding. If a write is accepted (IDLE, wr_en=1) and rd_addr[k]==wr_addr, then rd_data[k]=wr_data combinationally in that cycle. Rejected writes are never forwarded.
- Undefined: rd_data[k] returns the pre-write register value in the write cycle.
- dbg_regs is never bypassed.

Decomposition:
- Package regfile_pkg holds:
  - default DATA_W and ADDR_W constants;
  - typedef enum logic {RF_IDLE, RF_SWEEP} rf_state_t.
- Sub-module regfile_read_port: one DEPTH:1 mux plus the optional bypass comparator. It is instantiated NUM_RD times in a generate loop.
- The top level owns the storage array, the write/sweep arbitration and the FSM.

Test Plan:
- Reset/write/read, DATA_W=16, NUM_RD=2:
  - hold rst_n=0 for 2 cycles -> dbg_regs all 0;
  - write 0xBEEF to addr 5 -> next cycle rd_addr0=5 reads 0xBEEF;
  - rd_addr1=3 reads 0.
- Multiport read, NUM_RD=4:
  - fill reg i with 0x1111*i;
  - set rd_addr={7,0,7,2} -> rd_data={0x7777,0x0000,0x7777,0x2222}.
- Sweep timing:
  - preload all regs with 0xFFFF, pulse clr_req;
  - clr_busy high for exactly 8 cycles; clr_done pulses once in the 8th;
  - reg 3 reads 0 while reg 4 still reads 0xFFFF after 4 sweep cycles;
  - all regs 0 at the end.
- Collisions:
  - wr_en to addr 1 with 0x1234 during sweep -> wr_rej=1 that cycle and reg 1 ends 0;
  - clr_req mid-sweep -> sweep length still 8.
- Reset mid-sweep: assert rst_n=0 at sweep cycle 3 -> next cycle clr_busy=0, no clr_done pulse, all regs 0.
- Bypass:
  - with REGFILE_WR_BYPASS_EN: write 0xA5A5 to addr 2 with rd_addr0=2 -> same-cycle rd_data0=0xA5A5;
  - without the macro: the same stimulus returns the old value 0x0000.
